// File: rtl/song_lib_arb_pkg.sv
// Shared types and constants for the song-library arbiter.
// Requester ids, note/song widths, the end-of-song marker and the FSM state enum.
package song_lib_arb_pkg;

   localparam int NUM_REQ = 3;
   localparam int NOTE_W  = 5;
   localparam int SONG_W  = 3;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_REC   = 2'd0;
   localparam req_id_t REQ_AUTO  = 2'd1;
   localparam req_id_t REQ_LEARN = 2'd2;

   localparam logic [NOTE_W-1:0] END_NOTE = 5'b11111;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REWIND   = 3'd1,
      S_ACTIVE   = 3'd2,
      S_PULSE_HI = 3'd3,
      S_PULSE_LO = 3'd4,
      S_RELEASE  = 3'd5
   } arb_state_e;

   // (base + off) mod NUM_REQ for small ids
   function automatic req_id_t rr_add(input req_id_t base, input req_id_t off);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      return sum[1:0];
   endfunction

endpackage

// File: rtl/song_lib_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or above rr_ptr, wrapping.
module song_lib_rr_pick
   import song_lib_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  req_id_t            rr_ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic               valid
);

   logic [NUM_REQ-1:0] elig;
   req_id_t            idx;

   always_comb begin
      elig  = req & ~mask;
      pick  = '0;
      valid = 1'b0;
      idx   = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = rr_add(rr_ptr, req_id_t'(k));
         if (!valid && elig[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/song_lib_arbiter.sv
// Round-robin owner of the song-library port: rewind on grant, step pulses, read capture.
// Optional SONG_LIB_ARB_TIMEOUT_EN adds an idle timeout with a per-requester re-grant mask.
//
// state      | meaning
// IDLE       | no owner; arbitrate among req
// REWIND     | lib_back_to held for REWIND_CYC cycles
// ACTIVE     | owner granted, waiting for a step or release
// PULSE_HI   | lib_clk high for CLK_HI_CYC cycles
// PULSE_LO   | lib_clk low, read capture, step_done
// RELEASE    | drop grant, advance rr_ptr
module song_lib_arbiter
   import song_lib_arb_pkg::*;
#(
   parameter int unsigned REWIND_CYC  = 2,
   parameter int unsigned CLK_HI_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 1000
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          step,
   input  logic [NUM_REQ-1:0]          req_rw,
   input  logic [NUM_REQ*SONG_W-1:0]   req_song,
   input  logic [NUM_REQ*NOTE_W-1:0]   req_wr_note,
   input  logic [NOTE_W-1:0]           lib_in_note,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        step_done,
   output logic [NOTE_W-1:0]           rd_note,
   output logic                        song_end,
   output logic                        lib_clk,
   output logic                        lib_RorW,
   output logic                        lib_back_to,
   output logic [SONG_W-1:0]           lib_song_select,
   output logic [NOTE_W-1:0]           lib_wr_note
);

   localparam int unsigned PH_MAX = (REWIND_CYC > CLK_HI_CYC) ? REWIND_CYC : CLK_HI_CYC;
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0] REWIND_LD = PH_W'(REWIND_CYC - 1);
   localparam logic [PH_W-1:0] HI_LD     = PH_W'(CLK_HI_CYC - 1);

   arb_state_e          state_q, state_d;
   req_id_t             owner_q, owner_d;
   req_id_t             rr_ptr_q, rr_ptr_d;
   logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic                step_done_q, step_done_d;
   logic [NOTE_W-1:0]   rd_note_q, rd_note_d;
   logic                song_end_q, song_end_d;
   logic                lib_clk_q, lib_clk_d;
   logic                lib_rorw_q, lib_rorw_d;
   logic                lib_back_to_q, lib_back_to_d;
   logic [SONG_W-1:0]   lib_song_q, lib_song_d;
   logic [NOTE_W-1:0]   lib_wr_note_q, lib_wr_note_d;
   logic                go_release;

   logic [NUM_REQ-1:0]  arb_mask;
   logic [NUM_REQ-1:0]  pick_oh;
   logic                pick_vld;
   req_id_t             pick_id;

   logic [SONG_W-1:0]   song_arr    [NUM_REQ];
   logic [NOTE_W-1:0]   wr_note_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign song_arr[g]    = req_song[g*SONG_W +: SONG_W];
      assign wr_note_arr[g] = req_wr_note[g*NOTE_W +: NOTE_W];
   end

`ifdef SONG_LIB_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LD = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [NUM_REQ-1:0]  mask_q, mask_d;

   assign arb_mask = mask_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign arb_mask       = '0;
`endif

   song_lib_rr_pick u_pick (
      .req    (req),
      .mask   (arb_mask),
      .rr_ptr (rr_ptr_q),
      .pick   (pick_oh),
      .valid  (pick_vld)
   );

   always_comb begin
      pick_id = REQ_REC;
      if (pick_oh[REQ_AUTO])       pick_id = REQ_AUTO;
      else if (pick_oh[REQ_LEARN]) pick_id = REQ_LEARN;
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      ph_cnt_d      = ph_cnt_q;
      gnt_d         = gnt_q;
      step_done_d   = 1'b0;
      rd_note_d     = rd_note_q;
      song_end_d    = song_end_q;
      lib_clk_d     = lib_clk_q;
      lib_rorw_d    = lib_rorw_q;
      lib_back_to_d = lib_back_to_q;
      lib_song_d    = lib_song_q;
      lib_wr_note_d = lib_wr_note_q;
      go_release    = 1'b0;
`ifdef SONG_LIB_ARB_TIMEOUT_EN
      to_cnt_d      = to_cnt_q;
      mask_d        = mask_q & req;
`endif

      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               owner_d       = pick_id;
               gnt_d         = pick_oh;
               lib_song_d    = song_arr[pick_id];
               lib_rorw_d    = req_rw[pick_id];
               lib_back_to_d = 1'b1;
               ph_cnt_d      = REWIND_LD;
               state_d       = S_REWIND;
            end
         end

         S_REWIND: begin
            if (ph_cnt_q == '0) begin
               lib_back_to_d = 1'b0;
               state_d       = S_ACTIVE;
`ifdef SONG_LIB_ARB_TIMEOUT_EN
               to_cnt_d      = TO_LD;
`endif
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end

         S_ACTIVE: begin
            if (!req[owner_q]) begin
               go_release = 1'b1;
            end else if (step[owner_q] && !song_end_q) begin
               if (lib_rorw_q) lib_wr_note_d = wr_note_arr[owner_q];
               lib_clk_d = 1'b1;
               ph_cnt_d  = HI_LD;
               state_d   = S_PULSE_HI;
`ifdef SONG_LIB_ARB_TIMEOUT_EN
            end else if (to_cnt_q == '0) begin
               go_release      = 1'b1;
               mask_d[owner_q] = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q - 1'b1;
`endif
            end
         end

         S_PULSE_HI: begin
            if (ph_cnt_q == '0) begin
               lib_clk_d = 1'b0;
               state_d   = S_PULSE_LO;
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end

         S_PULSE_LO: begin
            step_done_d = 1'b1;
            if (!lib_rorw_q) begin
               rd_note_d = lib_in_note;
               if (lib_in_note == END_NOTE) song_end_d = 1'b1;
            end
            state_d = S_ACTIVE;
`ifdef SONG_LIB_ARB_TIMEOUT_EN
            to_cnt_d = TO_LD;
`endif
         end

         S_RELEASE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_release) begin
         state_d    = S_RELEASE;
         gnt_d      = '0;
         song_end_d = 1'b0;
         lib_rorw_d = 1'b0;
         rr_ptr_d   = rr_add(owner_q, 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         owner_q       <= REQ_REC;
         rr_ptr_q      <= REQ_REC;
         ph_cnt_q      <= '0;
         gnt_q         <= '0;
         step_done_q   <= 1'b0;
         rd_note_q     <= '0;
         song_end_q    <= 1'b0;
         lib_clk_q     <= 1'b0;
         lib_rorw_q    <= 1'b0;
         lib_back_to_q <= 1'b0;
         lib_song_q    <= '0;
         lib_wr_note_q <= '0;
`ifdef SONG_LIB_ARB_TIMEOUT_EN
         to_cnt_q      <= '0;
         mask_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         ph_cnt_q      <= ph_cnt_d;
         gnt_q         <= gnt_d;
         step_done_q   <= step_done_d;
         rd_note_q     <= rd_note_d;
         song_end_q    <= song_end_d;
         lib_clk_q     <= lib_clk_d;
         lib_rorw_q    <= lib_rorw_d;
         lib_back_to_q <= lib_back_to_d;
         lib_song_q    <= lib_song_d;
         lib_wr_note_q <= lib_wr_note_d;
`ifdef SONG_LIB_ARB_TIMEOUT_EN
         to_cnt_q      <= to_cnt_d;
         mask_q        <= mask_d;
`endif
      end
   end

   assign gnt             = gnt_q;
   assign step_done       = step_done_q;
   assign rd_note         = rd_note_q;
   assign song_end        = song_end_q;
   assign lib_clk         = lib_clk_q;
   assign lib_RorW        = lib_rorw_q;
   assign lib_back_to     = lib_back_to_q;
   assign lib_song_select = lib_song_q;
   assign lib_wr_note     = lib_wr_note_q;

endmodule

// File: tb/tb_song_lib_arbiter.sv
// Directed bench for song_lib_arbiter; the timeout section runs only with SONG_LIB_ARB_TIMEOUT_EN.
module tb_song_lib_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req, step, req_rw;
   logic [8:0]  req_song;
   logic [14:0] req_wr_note;
   logic [4:0]  lib_in_note;
   logic [2:0]  gnt;
   logic        step_done, song_end, lib_clk, lib_RorW, lib_back_to;
   logic [4:0]  rd_note, lib_wr_note;
   logic [2:0]  lib_song_select;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   song_lib_arbiter #(.REWIND_CYC(2), .CLK_HI_CYC(4), .TIMEOUT_CYC(20)) dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .step            (step),
      .req_rw          (req_rw),
      .req_song        (req_song),
      .req_wr_note     (req_wr_note),
      .lib_in_note     (lib_in_note),
      .gnt             (gnt),
      .step_done       (step_done),
      .rd_note         (rd_note),
      .song_end        (song_end),
      .lib_clk         (lib_clk),
      .lib_RorW        (lib_RorW),
      .lib_back_to     (lib_back_to),
      .lib_song_select (lib_song_select),
      .lib_wr_note     (lib_wr_note)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   logic [2:0] rr_exp [4];
   int zeros;

   initial begin
      rst = 1'b1; req = '0; step = '0; req_rw = '0;
      req_song = {3'd6, 3'd3, 3'd5};
      req_wr_note = {5'd21, 5'd9, 5'd12};
      lib_in_note = '0;
      repeat (2) tick();

      check("rst_gnt", gnt, 3'b000);
      check("rst_step_done", step_done, 0);
      check("rst_rd_note", rd_note, 0);
      check("rst_song_end", song_end, 0);
      check("rst_lib_clk", lib_clk, 0);
      check("rst_lib_rorw", lib_RorW, 0);
      check("rst_back_to", lib_back_to, 0);
      check("rst_song_sel", lib_song_select, 0);
      check("rst_wr_note", lib_wr_note, 0);

      // grant to auto-play, rewind to song 3
      rst = 1'b0;
      req = 3'b010;
      tick();
      check("grant_auto", gnt, 3'b010);
      check("rewind_1", lib_back_to, 1);
      check("rewind_song", lib_song_select, 3);
      tick();
      check("rewind_2", lib_back_to, 1);
      tick();
      check("rewind_end", lib_back_to, 0);

      // read step: 4 high, 1 low, done + capture on the 6th cycle
      step = 3'b010; lib_in_note = 5'd7;
      tick(); step = '0;
      for (int i = 1; i <= 4; i++) check($sformatf("pulse_hi_%0d", i), lib_clk, 1);
      tick(); tick(); tick();
      check("pulse_hi_4", lib_clk, 1);
      tick();
      check("pulse_lo", lib_clk, 0);
      check("done_early", step_done, 0);
      tick();
      check("done_pulse", step_done, 1);
      check("rd_note_7", rd_note, 7);
      tick();
      check("done_one_cycle", step_done, 0);

      // non-owner step ignored
      step = 3'b001;
      tick(); step = '0;
      check("nonowner_step", lib_clk, 0);

      // read end marker
      step = 3'b010; lib_in_note = 5'b11111;
      tick(); step = '0;
      repeat (5) tick();
      check("end_rd_note", rd_note, 5'h1f);
      check("end_song_end", song_end, 1);
      step = 3'b010;
      tick(); step = '0;
      check("end_step_blocked", lib_clk, 0);
      tick();
      check("end_step_blocked2", lib_clk, 0);
      req = '0;
      tick();
      check("rel_gnt", gnt, 0);
      check("rel_song_end", song_end, 0);
      tick();

      // recorder write
      req_rw = 3'b001; req = 3'b001;
      tick();
      check("wr_gnt", gnt, 3'b001);
      check("wr_rorw", lib_RorW, 1);
      check("wr_song", lib_song_select, 5);
      tick(); tick();
      step = 3'b001;
      tick(); step = '0;
      check("wr_clk", lib_clk, 1);
      check("wr_note", lib_wr_note, 12);
      check("wr_rorw_pulse", lib_RorW, 1);
      repeat (5) tick();
      check("wr_done", step_done, 1);
      check("wr_no_song_end", song_end, 0);

      // reset in the middle of a pulse
      step = 3'b001;
      tick(); step = '0;
      check("mid_clk", lib_clk, 1);
      tick();
      rst = 1'b1;
      req = 3'b111; req_rw = '0; lib_in_note = 5'd5;
      tick();
      check("mid_rst_clk", lib_clk, 0);
      check("mid_rst_gnt", gnt, 0);
      check("mid_rst_wr_note", lib_wr_note, 0);
      check("mid_rst_rorw", lib_RorW, 0);
      rst = 1'b0;

      // round-robin with all requesting
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
      for (int i = 0; i < 4; i++) begin
         zeros = 0;
         while (gnt == 3'b000 && zeros < 10) begin
            zeros++;
            tick();
         end
         check($sformatf("rr_gnt_%0d", i), gnt, rr_exp[i]);
         if (i > 0) check($sformatf("rr_gap_%0d", i), zeros, 2);
         tick(); tick();
         step = gnt;
         tick(); step = '0;
         repeat (5) tick();
         check($sformatf("rr_done_%0d", i), step_done, 1);
         req = req & ~gnt;
         tick();
         if (i == 0) req[0] = 1'b1;
      end
      tick();

`ifdef SONG_LIB_ARB_TIMEOUT_EN
      req = 3'b010;
      tick();
      check("to_gnt", gnt, 3'b010);
      tick(); tick();
      repeat (19) tick();
      check("to_held", gnt, 3'b010);
      tick();
      check("to_drop", gnt, 3'b000);
      repeat (4) tick();
      check("to_masked", gnt, 3'b000);
      req = '0;
      tick();
      req = 3'b010;
      tick();
      check("to_regrant", gnt, 3'b010);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
